pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector. It turns exceptions and ERET into a one-cycle flush with a redirect PC. It runs a memory-stall watchdog that forces a bus-error redirect, and it keeps a stall-cycle performance counter. It sits beside the pipeline and drives the stall, flush and new_pc inputs of the PC and of every pipeline register.

Parameters:
EBASE, 32'h0000_0020, exception vector address
TIMEOUT, 16, consecutive MEM-stall cycles that trigger a bus error (legal range 2..65535)
LOCK_CYCLES, 1, cycles after a flush during which requests are ignored (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallreq_id  in  1  ID stage stall request (load-use)
stallreq_ex  in  1  EX stage stall request (multi-cycle mult/div)
stallreq_mem  in  1  MEM stage stall request (bus wait)
excepttype_i  in  32  exception code from MEM; 0 means none
cp0_epc_i  in  32  current CP0 EPC value
stall  out  6  stall vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
flush  out  1  flush all pipeline registers and load new_pc
new_pc  out  32  redirect address, valid while flush=1
bus_err_o  out  1  one-cycle pulse when the watchdog fires
stall_cnt  out  32  count of cycles with stall[0]=1

Behaviour:
- Reset is synchronous and active-high on clk. The design is clocked only on the rising edge.
- stall, flush, new_pc and bus_err_o are combinational from state, counters and inputs.
- While rst=1, all outputs are forced to 0 in the same cycle. After reset: state=RUN, wd_cnt=0, lock_cnt=0, stall_cnt=0.
- FSM states: RUN and LOCKOUT.
- RUN, evaluated in priority order:
  1. excepttype_i != 0: flush=1, stall=6'b000000. Next state LOCKOUT, lock_cnt=LOCK_CYCLES-1, wd_cnt cleared.
     - new_pc = cp0_epc_i if excepttype_i == 32'h0000_000e (ERET).
     - new_pc = EBASE for every other nonzero code (interrupt 0x1, syscall 0x8, invalid instruction 0xa, overflow 0xc, trap 0xd, and any unknown code).
  2. stallreq_mem=1 and wd_cnt == TIMEOUT-1: flush=1, new_pc=EBASE, bus_err_o=1, stall=0. Next state LOCKOUT, wd_cnt cleared.
  3. Otherwise flush=0 and new_pc=0. stall is set by the highest-priority active request:
     - stallreq_mem=1 -> 6'b011111
     - else stallreq_ex=1 -> 6'b001111
     - else stallreq_id=1 -> 6'b000111
     - else 6'b000000
- LOCKOUT: stall=0, flush=0, new_pc=0. All requests and excepttype_i are ignored, because they come from squashed instructions. lock_cnt decrements each cycle. When lock_cnt==0, next state is RUN.
- Watchdog wd_cnt (16 bits):
  - Increments in RUN when stallreq_mem=1 and no flush occurs that cycle.
  - Clears in RUN when stallreq_mem=0, on any flush, and in LOCKOUT.
  - The watchdog therefore fires on the TIMEOUT-th consecutive stalled cycle.
- stall_cnt: increments by 1 on every cycle with stall[0]=1 and wraps from 32'hFFFF_FFFF to 0. It is cleared only by rst.
- Simultaneous events:
  - An exception beats the watchdog. bus_err_o=0 that cycle and new_pc follows the exception.
  - An exception beats any stall. stall=0 during flush so that the PC takes new_pc.
- An ERET and an interrupt cannot be distinguished when both are encoded; the single excepttype_i value is decoded as given.
- Reset asserted during LOCKOUT or mid-watchdog count returns to RUN with all counters 0 on the next edge.

Test Plan:
1. Reset, then stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle, stall_cnt=1 afterwards; all other outputs 0.
2. stallreq_id=stallreq_ex=stallreq_mem=1 for 3 cycles -> stall=6'b011111 each cycle, stall_cnt=3, no bus_err_o (wd_cnt reaches 3 < 15).
3. excepttype_i=32'h8 with stallreq_mem=1 -> same cycle flush=1, new_pc=32'h20, stall=0. Next cycle (LOCKOUT) excepttype_i=32'hc is ignored (flush=0). The cycle after, excepttype_i=32'hc gives flush=1.
4. cp0_epc_i=32'h0000_1234, excepttype_i=32'he -> flush=1, new_pc=32'h0000_1234.
5. stallreq_mem held high for 20 cycles -> cycles 1-15 give stall=6'b011111. Cycle 16 gives flush=1, bus_err_o=1, new_pc=32'h20. Cycle 17 (LOCKOUT) gives stall=0. Cycles 18-20 give stall=6'b011111 again with wd_cnt restarting at 0.
6. Force stall_cnt near wrap (stall held for 2^32-1 cycles, or via backdoor to 32'hFFFF_FFFF) then one stalled cycle -> stall_cnt=0. Assert rst during LOCKOUT -> next cycle state RUN and all outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-controller bundle: stall requests and exception info in, stall/flush/redirect out.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipeline_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_err_o;
    logic [31:0] stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, bus_err_o, stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, bus_err_o, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline controller: stall merging, exception/ERET flush and redirect,
// MEM-stall watchdog that forces a bus-error redirect, and a stall-cycle counter.
module pipeline_ctrl #(
    parameter logic [31:0] EBASE       = 32'h0000_0020,
    parameter int          TIMEOUT     = 16,
    parameter int          LOCK_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus,
    output logic           dbg_state_o
);

    typedef enum logic {
        RUN     = 1'b0,
        LOCKOUT = 1'b1
    } state_t;

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [3:0]  LOCK_INIT = 4'(LOCK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic [3:0]  lock_q, lock_d;
    logic [31:0] cnt_q, cnt_d;

    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        bus_err_c;

    always_comb begin
        stall_c   = 6'b000000;
        flush_c   = 1'b0;
        new_pc_c  = 32'h0;
        bus_err_c = 1'b0;
        state_d   = state_q;
        wd_d      = wd_q;
        lock_d    = lock_q;

        if (state_q == RUN) begin
            if (bus.excepttype_i != 32'h0) begin
                // Exception wins over the watchdog and every stall request.
                flush_c  = 1'b1;
                new_pc_c = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EBASE;
                state_d  = LOCKOUT;
                lock_d   = LOCK_INIT;
                wd_d     = 16'h0;
            end else if (bus.stallreq_mem && (wd_q == WD_LAST)) begin
                flush_c   = 1'b1;
                new_pc_c  = EBASE;
                bus_err_c = 1'b1;
                state_d   = LOCKOUT;
                lock_d    = LOCK_INIT;
                wd_d      = 16'h0;
            end else begin
                if (bus.stallreq_mem) begin
                    stall_c = 6'b011111;
                end else if (bus.stallreq_ex) begin
                    stall_c = 6'b001111;
                end else if (bus.stallreq_id) begin
                    stall_c = 6'b000111;
                end
                wd_d = bus.stallreq_mem ? (wd_q + 16'd1) : 16'h0;
            end
        end else begin
            // Requests seen here belong to squashed instructions.
            wd_d = 16'h0;
            if (lock_q == 4'd0) begin
                state_d = RUN;
            end else begin
                lock_d = lock_q - 4'd1;
            end
        end

        if (rst) begin
            stall_c   = 6'b000000;
            flush_c   = 1'b0;
            new_pc_c  = 32'h0;
            bus_err_c = 1'b0;
        end

        cnt_d = stall_c[0] ? (cnt_q + 32'd1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wd_q    <= 16'h0;
            lock_q  <= 4'd0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.flush     = flush_c;
    assign bus.new_pc    = new_pc_c;
    assign bus.bus_err_o = bus_err_c;
    assign bus.stall_cnt = rst ? 32'h0 : cnt_q;
    assign dbg_state_o   = rst ? 1'b0 : (state_q == LOCKOUT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic against a behavioural model,
// expected responses queued by the driver and checked by an independent monitor.
module tb_pipeline_ctrl;

    localparam logic [31:0] EBASE       = 32'h0000_0020;
    localparam int          TIMEOUT     = 16;
    localparam int          LOCK_CYCLES = 1;

    logic clk;
    logic rst;
    logic dbg_state;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(
        .EBASE      (EBASE),
        .TIMEOUT    (TIMEOUT),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst              = 1'b1;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excepttype_i = 32'h0;
        bus.cp0_epc_i    = 32'h0;
    end

    // ---------------- behavioural model ----------------
    // Expected record: {lockout, bus_err, flush, stall[5:0], new_pc, stall_cnt}
    logic [72:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    bit          m_locked    = 1'b0;
    int          m_lock_left = 0;
    int          m_run_len   = 0;   // consecutive MEM-stalled cycles seen so far
    logic [31:0] m_cnt       = 32'h0;

    task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                         input logic [31:0] exc, input logic [31:0] epc);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_berr;
        logic [31:0] e_pc;
        logic        e_state;
        logic [31:0] e_cnt;
        @(negedge clk);
        rst              = r;
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.excepttype_i = exc;
        bus.cp0_epc_i    = epc;

        e_stall = 6'd0;
        e_flush = 1'b0;
        e_berr  = 1'b0;
        e_pc    = 32'h0;
        e_state = r ? 1'b0 : m_locked;
        e_cnt   = r ? 32'h0 : m_cnt;

        if (r) begin
            m_locked    = 1'b0;
            m_lock_left = 0;
            m_run_len   = 0;
            m_cnt       = 32'h0;
        end else if (m_locked) begin
            m_run_len   = 0;
            m_lock_left = m_lock_left - 1;
            if (m_lock_left == 0) m_locked = 1'b0;
        end else if (exc != 32'h0) begin
            e_flush     = 1'b1;
            e_pc        = (exc == 32'h0000_000e) ? epc : EBASE;
            m_locked    = 1'b1;
            m_lock_left = LOCK_CYCLES;
            m_run_len   = 0;
        end else if (mem && (m_run_len + 1 == TIMEOUT)) begin
            e_flush     = 1'b1;
            e_berr      = 1'b1;
            e_pc        = EBASE;
            m_locked    = 1'b1;
            m_lock_left = LOCK_CYCLES;
            m_run_len   = 0;
        end else begin
            if (mem)     e_stall = 6'b011111;
            else if (ex) e_stall = 6'b001111;
            else if (id) e_stall = 6'b000111;
            m_run_len = mem ? m_run_len + 1 : 0;
        end
        if (!r && e_stall[0]) m_cnt = m_cnt + 32'd1;

        exp_q.push_back({e_state, e_berr, e_flush, e_stall, e_pc, e_cnt});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [72:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state",     {31'h0, dbg_state},     {31'h0, e[72]});
                check("bus_err",   {31'h0, bus.bus_err_o}, {31'h0, e[71]});
                check("flush",     {31'h0, bus.flush},     {31'h0, e[70]});
                check("stall",     {26'h0, bus.stall},     {26'h0, e[69:64]});
                check("new_pc",    bus.new_pc,             e[63:32]);
                check("stall_cnt", bus.stall_cnt,          e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] codes [7];

    initial begin
        logic [31:0] exc;
        int          k;
        codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'hc;
        codes[4] = 32'hd; codes[5] = 32'he; codes[6] = 32'h0;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0);

        // single load-use stall
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        // all requests together
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
        idle();
        // exception over stall, lockout ignores the next one
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hc, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hc, 32'h0);
        idle();
        idle();
        // ERET
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h0000_1234);
        idle();
        // watchdog
        repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        idle();
        // exception on the watchdog's firing cycle
        repeat (15) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0);
        idle();
        idle();

        // stall counter wrap via backdoor
        @(posedge clk);
        #1 force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // reset during lockout and mid-watchdog
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hd, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        idle();
        repeat (7) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        repeat (16) drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

        // random traffic, MEM stalls biased into long runs
        for (int i = 0; i < 800; i++) begin
            exc = 32'h0;
            if ($urandom_range(0, 29) == 0) begin
                k   = $urandom_range(0, 6);
                exc = (k == 6) ? ($urandom | 32'h1) : codes[k];
            end
            drive(($urandom_range(0, 249) == 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 19) != 0),
                  exc,
                  $urandom);
        end
        idle();

        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
